// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, key schedule supplied expanded.
// Round key r sits at key[(NR+1-r)*128-1 -: 128]; state byte 0 is bits [127:120].
module aes_inv_cipher_iter #(
    parameter int NK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [127:0]             in_block,
    input  logic [4*(NK+7)*32-1:0]   key,
    output logic                     busy,
    output logic                     done,
    output logic [127:0]             out_block
);

    localparam int NR = NK + 6;

    // state  | meaning
    // IDLE   | waiting for start; out_block holds the last result
    // ROUND  | full inverse rounds, rk(ctr) with ctr counting NR-1 down to 1
    // FINAL  | last round without InvMixColumns, rk(0), pulses done
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t         state, state_nx;
    logic [3:0]     ctr, ctr_d;
    logic [127:0]   st, st_d;
    logic [127:0]   out_d;
    logic           done_d;
    logic [127:0]   rk [0:NR];

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign rk[r] = key[(NR+1-r)*128-1 -: 128];
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++)
            y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8];
        return ginv(y ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ROUND;
            ROUND:   if (ctr == 4'd1) state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        st_d   = st;
        ctr_d  = ctr;
        out_d  = out_block;
        done_d = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    st_d  = in_block ^ rk[NR];
                    ctr_d = 4'(NR - 1);
                end
            end
            ROUND: begin
                st_d  = inv_mix(inv_sub(inv_shift(st)) ^ rk[ctr]);
                ctr_d = ctr - 4'd1;
            end
            FINAL: begin
                out_d  = inv_sub(inv_shift(st)) ^ rk[0];
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= '0;
            ctr       <= '0;
            out_block <= '0;
            done      <= 1'b0;
        end else begin
            st        <= st_d;
            ctr       <= ctr_d;
            out_block <= out_d;
            done      <= done_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter with NK=4/6/8 instances and an expected-plaintext queue.
module tb_aes_inv_cipher_iter;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
    logic [127:0]   ct_bus = '0;
    logic [1407:0]  key4 = '0;
    logic [1663:0]  key6 = '0;
    logic [1919:0]  key8 = '0;
    logic           busy4, busy6, busy8, done4, done6, done8;
    logic [127:0]   out4, out6, out8;

    int             total = 0;
    int             bad = 0;
    int             sel = 0;
    logic           busy_s, done_s;
    logic [127:0]   out_s;
    logic [127:0]   exp_q [$];
    logic [1919:0]  full;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .in_block(ct_bus),
        .key(key4), .busy(busy4), .done(done4), .out_block(out4));
    aes_inv_cipher_iter #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .in_block(ct_bus),
        .key(key6), .busy(busy6), .done(done6), .out_block(out6));
    aes_inv_cipher_iter #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .in_block(ct_bus),
        .key(key8), .busy(busy8), .done(done8), .out_block(out8));

    always_comb begin
        case (sel)
            1:       begin busy_s = busy6; done_s = done6; out_s = out6; end
            2:       begin busy_s = busy8; done_s = done8; out_s = out8; end
            default: begin busy_s = busy4; done_s = done4; out_s = out4; end
        endcase
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] y, t;
        for (int i = 0; i < 254; i++) r = gm(r, x);
        y = r;
        t = r;
        for (int i = 0; i < 4; i++) begin
            t = {t[6:0], t[7]};
            y = y ^ t;
        end
        return y ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // FIPS-197 key expansion; w[0] lands at the MSBs of the 1920-bit bus
    function automatic logic [1919:0] expand(input int nk, input logic [255:0] k);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] bus = '0;
        int            nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) bus[1919-32*i -: 32] = w[i];
        return bus;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       start6 = v;
            2:       start8 = v;
            default: start4 = v;
        endcase
    endtask

    task automatic start_op(input int s, input logic [127:0] ct, input logic [127:0] pt, input string tag);
        sel    = s;
        ct_bus = ct;
        set_start(s, 1'b1);
        exp_q.push_back(pt);
        @(negedge clk);
        set_start(s, 1'b0);
        check({tag, "_busy_e0"}, 128'(busy_s), 128'd1);
    endtask

    // entered on the negedge after the accepting edge; returns on the done negedge
    task automatic wait_done(input string tag, input int nr, input bit ign);
        int           cyc = 0;
        bit           got = 0;
        int           busy_gap = 0;
        int           held_bad = 0;
        logic [127:0] prev = out_s;
        logic [127:0] exp;
        while (!got && cyc < 60) begin
            if (ign && (cyc == 3 || cyc == 7)) begin
                set_start(sel, 1'b1);
                ct_bus = 128'hdeadbeef_0badf00d_cafebabe_12345678;
            end else if (ign && (cyc == 4 || cyc == 8)) begin
                set_start(sel, 1'b0);
            end
            @(negedge clk);
            cyc++;
            if (done_s) got = 1;
            else begin
                if (!busy_s) busy_gap++;
                if (out_s !== prev) held_bad++;
            end
        end
        set_start(sel, 1'b0);
        check({tag, "_done_seen"}, 128'(got), 128'd1);
        check({tag, "_latency"}, 128'(cyc), 128'(nr));
        check({tag, "_busy_gaps"}, 128'(busy_gap), 128'd0);
        check({tag, "_out_held"}, 128'(held_bad), 128'd0);
        check({tag, "_busy_at_done"}, 128'(busy_s), 128'd0);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_plaintext"}, out_s, exp);
        end else begin
            check({tag, "_queue_underflow"}, 128'(exp_q.size()), 128'd1);
        end
    endtask

    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        int extra;

        // reset state
        #12;
        check("rst_busy4", 128'(busy4), 128'd0);
        check("rst_done4", 128'(done4), 128'd0);
        check("rst_out4", out4, 128'd0);
        check("rst_out8", out8, 128'd0);
        check("rst_state4", dut4.st, 128'd0);
        check("rst_ctr4", 128'(dut4.ctr), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // App. B
        full = expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        key4 = full[1919:512];
        start_op(0, CT_B, 128'h3243f6a8885a308d313198a2e0370734, "appb");
        check("appb_state_e0", dut4.st, CT_B ^ 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("appb_ctr_e0", 128'(dut4.ctr), 128'd9);
        wait_done("appb", 10, 1'b0);
        @(negedge clk);
        check("appb_done_width", 128'(done4), 128'd0);

        // C.1 with ignored starts at cycles 3 and 7
        full = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        key4 = full[1919:512];
        start_op(0, CT_1, PT_C, "c1ign");
        wait_done("c1ign", 10, 1'b1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4) extra++;
        end
        check("c1ign_single_done", 128'(extra), 128'd0);
        check("c1ign_out_kept", out4, PT_C);

        // back-to-back: second start lands in the done cycle
        start_op(0, CT_B ^ CT_B ^ CT_1, PT_C, "b2b_a");
        wait_done("b2b_a", 10, 1'b0);
        start_op(0, CT_1, PT_C, "b2b_b");
        check("b2b_out_held_e0", out4, PT_C);
        wait_done("b2b_b", 10, 1'b0);

        // asynchronous reset at cycle 5 of an operation
        start_op(0, CT_1, PT_C, "rstmid");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", 128'(busy4), 128'd0);
        check("rstmid_done", 128'(done4), 128'd0);
        check("rstmid_out", out4, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        extra = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done4 || busy4) extra++;
        end
        check("rstmid_no_done", 128'(extra), 128'd0);
        start_op(0, CT_1, PT_C, "rstafter");
        wait_done("rstafter", 10, 1'b0);

        // C.2 and C.3
        full = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        key6 = full[1919:256];
        @(negedge clk);
        start_op(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C, "c2");
        wait_done("c2", 12, 1'b0);
        full = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        key8 = full;
        @(negedge clk);
        start_op(2, 128'h8ea2b7ca516745bfeafc49904b496089, PT_C, "c3");
        wait_done("c3", 14, 1'b0);
        @(negedge clk);
        check("c3_done_width", 128'(done8), 128'd0);
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
